// File: rtl/tx_fifo_mgnt.sv
// Transmit FIFO manager: buffers client words and streams complete frames to the TX engine.
// Define TX_UNDERRUN_FLUSH_EN to discard the rest of a frame after underrun instead of stalling.
module tx_fifo_mgnt #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned START_THRESH = 4
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic [63:0]         tx_data,
  input  logic [7:0]          tx_data_valid,
  input  logic                tx_start,
  input  logic                tx_end,
  output logic                tx_ready,
  output logic [63:0]         txd64,
  output logic [7:0]          txc_fifo,
  output logic                tx_en,
  output logic                tx_sof,
  output logic                tx_eof,
  output logic                tx_underrun,
  output logic [DEPTH_LOG2:0] fifo_level
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  val;
    logic        sof;
    logic        eof;
  } entry_t;

`ifdef TX_UNDERRUN_FLUSH_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_IFG, ST_FLUSH} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_IFG} state_t;
`endif

  entry_t r_mem [DEPTH];
  ptr_t   r_wr_ptr;
  ptr_t   r_rd_ptr;
  lvl_t   r_level;
  lvl_t   r_frames;
  state_t r_state;
  logic   r_urun_seen;
  logic   r_s1_en;
  entry_t r_s1;

  logic   w_wr;
  logic   w_pop;
  logic   w_fwd;
  logic   w_urun;
  logic   w_empty;
  logic   w_can_start;
  entry_t w_head;

  assign w_empty     = (r_level == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign tx_ready    = (r_level != lvl_t'(DEPTH)) & ~reset;
  assign w_wr        = (|tx_data_valid) & tx_ready;
  assign w_can_start = (r_frames != '0) || (32'(r_level) >= START_THRESH);
  assign fifo_level  = r_level;

  // w_pop advances the read pointer; w_fwd marks pops that reach the outputs
  always_comb begin
    w_pop  = 1'b0;
    w_fwd  = 1'b0;
    w_urun = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (!w_head.sof) begin
            w_pop = 1'b1;
          end else if (w_can_start) begin
            w_pop = 1'b1;
            w_fwd = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          w_fwd = 1'b1;
        end else begin
          w_urun = 1'b1;
        end
      end
`ifdef TX_UNDERRUN_FLUSH_EN
      ST_FLUSH: w_pop = !w_empty;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= '{data: tx_data, val: tx_data_valid, sof: tx_start, eof: tx_end};
    end
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_frames    <= '0;
      r_state     <= ST_IDLE;
      r_urun_seen <= 1'b0;
      r_s1_en     <= 1'b0;
      r_s1        <= '0;
      tx_en       <= 1'b0;
      txd64       <= '0;
      txc_fifo    <= '0;
      tx_sof      <= 1'b0;
      tx_eof      <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + ptr_t'(1);

      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + lvl_t'(1);
        2'b01:   r_level <= r_level - lvl_t'(1);
        default: ;
      endcase

      case ({w_wr & tx_end, w_pop & w_head.eof})
        2'b10:   r_frames <= r_frames + lvl_t'(1);
        2'b01:   r_frames <= r_frames - lvl_t'(1);
        default: ;
      endcase

      // Two-stage output: pop into s1, then s1 onto the registered outputs
      r_s1_en  <= w_fwd;
      r_s1     <= w_fwd ? w_head : '0;
      tx_en    <= r_s1_en;
      txd64    <= r_s1.data;
      txc_fifo <= r_s1.val;
      tx_sof   <= r_s1.sof;
      tx_eof   <= r_s1.eof;

      // Pulse once per underrun episode, re-armed by the next pop
      tx_underrun <= w_urun & ~r_urun_seen;
      if (w_urun)     r_urun_seen <= 1'b1;
      else if (w_pop) r_urun_seen <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_fwd) r_state <= w_head.eof ? ST_IFG : ST_SEND;
        end
        ST_SEND: begin
          if (w_pop && w_head.eof) r_state <= ST_IFG;
`ifdef TX_UNDERRUN_FLUSH_EN
          else if (w_urun)         r_state <= ST_FLUSH;
`endif
        end
        ST_IFG: r_state <= ST_IDLE;
`ifdef TX_UNDERRUN_FLUSH_EN
        ST_FLUSH: begin
          if (w_pop && w_head.eof) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_mgnt.sv
// Directed bench for tx_fifo_mgnt: default instance plus a START_THRESH=16 instance for the full case.
module tb_tx_fifo_mgnt;
  logic        txclk = 1'b0;
  logic        reset;

  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_start, tx_end;
  logic        tx_ready;
  logic [63:0] txd64;
  logic [7:0]  txc_fifo;
  logic        tx_en, tx_sof, tx_eof, tx_underrun;
  logic [4:0]  fifo_level;

  logic [63:0] f_tx_data;
  logic [7:0]  f_tx_data_valid;
  logic        f_tx_start, f_tx_end;
  logic        f_tx_ready;
  logic [63:0] f_txd64;
  logic [7:0]  f_txc_fifo;
  logic        f_tx_en, f_tx_sof, f_tx_eof, f_tx_underrun;
  logic [4:0]  f_fifo_level;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] mon_data[$];
  int          mon_eofs = 0;
  int          mon_urun = 0;

  always #5 txclk = ~txclk;

  tx_fifo_mgnt #(.DEPTH_LOG2(4), .START_THRESH(4)) dut (
    .txclk(txclk), .reset(reset), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_start(tx_start), .tx_end(tx_end), .tx_ready(tx_ready), .txd64(txd64),
    .txc_fifo(txc_fifo), .tx_en(tx_en), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .tx_underrun(tx_underrun), .fifo_level(fifo_level)
  );

  tx_fifo_mgnt #(.DEPTH_LOG2(4), .START_THRESH(16)) dut_f (
    .txclk(txclk), .reset(reset), .tx_data(f_tx_data), .tx_data_valid(f_tx_data_valid),
    .tx_start(f_tx_start), .tx_end(f_tx_end), .tx_ready(f_tx_ready), .txd64(f_txd64),
    .txc_fifo(f_txc_fifo), .tx_en(f_tx_en), .tx_sof(f_tx_sof), .tx_eof(f_tx_eof),
    .tx_underrun(f_tx_underrun), .fifo_level(f_fifo_level)
  );

  always @(negedge txclk) begin
    if (tx_en) begin
      mon_data.push_back(txd64);
      if (tx_eof) mon_eofs++;
    end
    if (tx_underrun) mon_urun++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge txclk);
    #1;
  endtask

  task automatic push(input bit f, input logic [63:0] d, input logic [7:0] v,
                      input logic s, input logic e);
    if (f) begin
      f_tx_data = d; f_tx_data_valid = v; f_tx_start = s; f_tx_end = e;
    end else begin
      tx_data = d; tx_data_valid = v; tx_start = s; tx_end = e;
    end
    tick();
    tx_data = '0; tx_data_valid = '0; tx_start = 1'b0; tx_end = 1'b0;
    f_tx_data = '0; f_tx_data_valid = '0; f_tx_start = 1'b0; f_tx_end = 1'b0;
  endtask

  int base_n, base_eof, base_urun;

  initial begin
    reset = 1'b1;
    tx_data = '0; tx_data_valid = '0; tx_start = 1'b0; tx_end = 1'b0;
    f_tx_data = '0; f_tx_data_valid = '0; f_tx_start = 1'b0; f_tx_end = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_en", tx_en, 0);
    check("rst_data", txd64, 0);
    check("rst_txc", txc_fifo, 0);
    check("rst_sofeof", {tx_sof, tx_eof, tx_underrun}, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_f_level", f_fifo_level, 0);
    reset = 1'b0;
    #1;
    check("rel_ready", tx_ready, 1);
    tick();

    // basic 3-word frame
    push(0, 64'h0123456789ABCDEF, 8'hFF, 1, 0);
    push(0, 64'hFEDCBA9876543210, 8'hFF, 0, 0);
    push(0, 64'h00000000CAFEF00D, 8'h0F, 0, 1);
    check("b_lat0", tx_en, 0);
    tick(); check("b_lat1", tx_en, 0);
    tick();
    check("b_w0_en", tx_en, 1); check("b_w0_sof", tx_sof, 1); check("b_w0_eof", tx_eof, 0);
    check("b_w0_data", txd64, 64'h0123456789ABCDEF); check("b_w0_txc", txc_fifo, 8'hFF);
    tick();
    check("b_w1_en", tx_en, 1); check("b_w1_sof", tx_sof, 0);
    check("b_w1_data", txd64, 64'hFEDCBA9876543210);
    tick();
    check("b_w2_en", tx_en, 1); check("b_w2_eof", tx_eof, 1);
    check("b_w2_data", txd64, 64'h00000000CAFEF00D); check("b_w2_txc", txc_fifo, 8'h0F);
    tick();
    check("b_ifg_en", tx_en, 0); check("b_ifg_eof", tx_eof, 0);
    check("b_ifg_data", txd64, 0); check("b_level", fifo_level, 0);

    // fill to full on the high-threshold instance
    push(1, 64'hC000, 8'hFF, 1, 0);
    for (int i = 1; i < 16; i++) push(1, 64'hC000 + 64'(i), 8'hFF, 0, 0);
    check("full_level", f_fifo_level, 16);
    check("full_ready", f_tx_ready, 0);
    f_tx_data = 64'hDEAD; f_tx_data_valid = 8'hFF;
    tick();
    f_tx_data = '0; f_tx_data_valid = '0;
    check("full_refuse", f_fifo_level, 15);
    tick();
    check("full_out_en", f_tx_en, 1); check("full_out_sof", f_tx_sof, 1);
    check("full_out_eof", f_tx_eof, 0); check("full_out_data", f_txd64, 64'hC000);
    check("full_out_txc", f_txc_fifo, 8'hFF); check("full_urun", f_tx_underrun, 0);
    check("full_level2", f_fifo_level, 14);

    // stray word then single-word frame
    push(0, 64'h5757575757575757, 8'hFF, 0, 0);
    push(0, 64'h1F1F1F1F1F1F1F1F, 8'h3C, 1, 1);
    check("s_en0", tx_en, 0);
    tick(); check("s_en1", tx_en, 0);
    tick();
    check("s_en2", tx_en, 1); check("s_data", txd64, 64'h1F1F1F1F1F1F1F1F);
    check("s_txc", txc_fifo, 8'h3C); check("s_sofeof", {tx_sof, tx_eof}, 2'b11);
    tick(); check("s_after", tx_en, 0);

    // back-to-back 2-word frames
    push(0, 64'hA0, 8'hFF, 1, 0);
    push(0, 64'hA1, 8'hFF, 0, 1);
    push(0, 64'hB0, 8'hFF, 1, 0);
    push(0, 64'hB1, 8'hFF, 0, 1);
    check("bb_a0", {tx_en, tx_sof, txd64}, {2'b11, 64'hA0});
    tick(); check("bb_a1", {tx_en, tx_eof, txd64}, {2'b11, 64'hA1});
    tick(); check("bb_gap", tx_en, 0);
    tick(); check("bb_b0", {tx_en, tx_sof, txd64}, {2'b11, 64'hB0});
    tick(); check("bb_b1", {tx_en, tx_eof, txd64}, {2'b11, 64'hB1});
    check("bb_frames", dut.r_frames, 0);
    tick();

    // threshold start and underrun
    base_n = mon_data.size(); base_eof = mon_eofs; base_urun = mon_urun;
    push(0, 64'hF0, 8'hFF, 1, 0);
    for (int i = 1; i < 4; i++) push(0, 64'hF0 + 64'(i), 8'hFF, 0, 0);
    tick(); check("t_wait", tx_en, 0);
    tick(); check("t_f0", {tx_en, tx_sof, txd64}, {2'b11, 64'hF0});
    tick(); tick();
    tick(); check("t_f3", {tx_en, tx_eof, txd64}, {2'b10, 64'hF3});
    check("t_urun_hi", tx_underrun, 1);
    tick(); check("t_urun_lo", {tx_underrun, tx_en}, 0);
    repeat (3) tick();
    for (int i = 4; i < 10; i++) push(0, 64'hF0 + 64'(i), 8'hFF, 0, (i == 9));
    repeat (6) tick();
    push(0, 64'h77, 8'hFF, 1, 1);
    repeat (4) tick();
    check("t_urun_cnt", mon_urun - base_urun, 1);
    check("t_level", fifo_level, 0);
`ifdef TX_UNDERRUN_FLUSH_EN
    check("t_words", mon_data.size() - base_n, 5);
    check("t_eofs", mon_eofs - base_eof, 1);
    check("t_next", mon_data[base_n + 4], 64'h77);
`else
    check("t_words", mon_data.size() - base_n, 11);
    check("t_eofs", mon_eofs - base_eof, 2);
    check("t_resume", mon_data[base_n + 4], 64'hF4);
    check("t_last", mon_data[base_n + 9], 64'hF9);
    check("t_next", mon_data[base_n + 10], 64'h77);
`endif

    // reset mid-frame
    base_urun = mon_urun;
    push(0, 64'hE0, 8'hFF, 1, 0);
    for (int i = 1; i < 4; i++) push(0, 64'hE0 + 64'(i), 8'hFF, 0, 0);
    tick(); tick();
    check("r_sending", {tx_en, txd64}, {1'b1, 64'hE0});
    reset = 1'b1;
    tick();
    check("r_en", {tx_en, tx_sof, tx_eof, tx_underrun}, 0);
    check("r_data", {txd64, txc_fifo}, 0);
    check("r_level", fifo_level, 0);
    check("r_ready", tx_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r_quiet", {tx_en, tx_underrun}, 0);
    end
    check("r_urun_cnt", mon_urun - base_urun, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
